axil_read_arbiter: RTL and testbench

//  Two-master, one-slave AXI4-Lite read-channel arbiter. Shares one read slave (the register

---
 rtl/axil_pkg.sv | 21 ++
 rtl/axil_rr_pick2.sv | 29 ++
 rtl/axil_read_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_axil_read_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axil_pkg
// Description : Shared definitions for the AXI4-Lite read arbiter. Provides the
//               AXI read response codes and the 2-bit arbiter FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : axil_rr_pick2
// Description : Combinational two-way round-robin pick.
//               req  [1:0] : request vector (bit N = requester N valid)
//               last       : index of the requester granted most recently
//               gnt  [1:0] : one-hot winner, 0 when no request
//               A sole requester always wins; on a tie the requester that was
//               not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axil_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axil_read_arbiter
// Description : Two-master, one-slave AXI4-Lite read-channel arbiter.
//               Round-robin between requesters s0/s1 with a single transaction
//               in flight. A slave that stalls on R for C_TIMEOUT data cycles is
//               timed out: the owner receives SLVERR with zero data and the late
//               response, whenever it arrives, is drained and discarded.
// Ports       : aclk/aresetn        clock, async active-low reset
//               sN_ar*              requester N read-address channel
//               sN_r*               requester N read-data channel
//               m_ar*               read-address channel to the shared slave
//               m_r*                read-data channel from the shared slave
//               grant               one-hot owner of current transaction
//               timeout_err         one-cycle pulse when a timeout fires
// Revision    : 1.0 - initial release
// ============================================================================
module axil_read_arbiter
    import axil_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 4,
    parameter int C_TIMEOUT        = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,

    input  logic [C_AXI_ADDR_WIDTH-1:0] s0_araddr,
    input  logic [2:0]                  s0_arprot,
    input  logic                        s0_arvalid,
    output logic                        s0_arready,
    output logic [C_AXI_DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]                  s0_rresp,
    output logic                        s0_rvalid,
    input  logic                        s0_rready,

    input  logic [C_AXI_ADDR_WIDTH-1:0] s1_araddr,
    input  logic [2:0]                  s1_arprot,
    input  logic                        s1_arvalid,
    output logic                        s1_arready,
    output logic [C_AXI_DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]                  s1_rresp,
    output logic                        s1_rvalid,
    input  logic                        s1_rready,

    output logic [C_AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]                  m_arprot,
    output logic                        m_arvalid,
    input  logic                        m_arready,

    input  logic [C_AXI_DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]                  m_rresp,
    input  logic                        m_rvalid,
    output logic                        m_rready,

    output logic [1:0]                  grant,
    output logic                        timeout_err
);

    // Counter only needs to reach C_TIMEOUT-1.
    localparam int              CNT_W    = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT - 1);
    localparam bit              TO_EN    = (C_TIMEOUT != 0);

    arb_state_t                  state;
    arb_state_t                  state_nxt;
    logic                        last_grant;   // 0 = s0 granted last, 1 = s1
    logic                        drain;
    logic [CNT_W-1:0]            cnt;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                  rresp_q;

    logic [1:0]                  pick_gnt;
    logic                        arb_en;
    logic                        ar_hs;
    logic                        r_hs;
    logic                        to_hit;

    axil_rr_pick2 u_pick (
        .req  ({s1_arvalid, s0_arvalid}),
        .last (last_grant),
        .gnt  (pick_gnt)
    );

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        arb_en     = 1'b0;
        ar_hs      = 1'b0;
        r_hs       = 1'b0;
        to_hit     = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        // A pending drain keeps R ready open outside DATA so the late
        // response of a timed-out read is swallowed here.
        m_rready   = drain;

        case (state)
            ST_IDLE: begin
                arb_en     = !drain;
                s0_arready = arb_en && pick_gnt[0];
                s1_arready = arb_en && pick_gnt[1];
                ar_hs      = arb_en && (pick_gnt != 2'b00);
                if (ar_hs) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_arready) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                m_rready = 1'b1;
                // Real data in the threshold cycle takes priority.
                to_hit   = TO_EN && (cnt == CNT_LAST) && !m_rvalid;
                if (m_rvalid || to_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                s0_rvalid = grant[0];
                s1_rvalid = grant[1];
                r_hs      = (grant[0] && s0_rready) || (grant[1] && s1_rready);
                if (r_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address/grant latches, timeout counter, drain flag, response latch
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_araddr    <= '0;
            m_arprot    <= '0;
            m_arvalid   <= 1'b0;
            grant       <= 2'b00;
            last_grant  <= 1'b1;
            drain       <= 1'b0;
            cnt         <= '0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;

            if (ar_hs) begin
                m_araddr  <= pick_gnt[1] ? s1_araddr : s0_araddr;
                m_arprot  <= pick_gnt[1] ? s1_arprot : s0_arprot;
                m_arvalid <= 1'b1;
                grant     <= pick_gnt;
            end

            if (state == ST_ADDR && m_arready) begin
                m_arvalid <= 1'b0;
                cnt       <= '0;
            end

            if (state == ST_DATA) begin
                if (m_rvalid) begin
                    rdata_q <= m_rdata;
                    rresp_q <= m_rresp;
                end else if (to_hit) begin
                    rdata_q     <= '0;
                    rresp_q     <= RESP_SLVERR;
                    timeout_err <= 1'b1;
                    drain       <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (drain && m_rvalid) begin
                drain <= 1'b0;
            end

            if (r_hs) begin
                last_grant <= grant[1];
                grant      <= 2'b00;
                rdata_q    <= '0;
                rresp_q    <= RESP_OKAY;
            end
        end
    end

    // Response is only visible on the owner's port; the other port reads 0.
    assign s0_rdata = grant[0] ? rdata_q : '0;
    assign s0_rresp = grant[0] ? rresp_q : RESP_OKAY;
    assign s1_rdata = grant[1] ? rdata_q : '0;
    assign s1_rresp = grant[1] ? rresp_q : RESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_axil_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_read_arbiter
// Description : Directed self-checking bench for axil_read_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_read_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  s0_araddr, s1_araddr, m_araddr;
    logic [2:0]  s0_arprot, s1_arprot, m_arprot;
    logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
    logic [31:0] s0_rdata, s1_rdata, m_rdata;
    logic [1:0]  s0_rresp, s1_rresp, m_rresp;
    logic        s0_rvalid, s1_rvalid, s0_rready, s1_rready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  grant;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    axil_read_arbiter #(
        .C_AXI_DATA_WIDTH (32),
        .C_AXI_ADDR_WIDTH (4),
        .C_TIMEOUT        (16)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s0_araddr   (s0_araddr),
        .s0_arprot   (s0_arprot),
        .s0_arvalid  (s0_arvalid),
        .s0_arready  (s0_arready),
        .s0_rdata    (s0_rdata),
        .s0_rresp    (s0_rresp),
        .s0_rvalid   (s0_rvalid),
        .s0_rready   (s0_rready),
        .s1_araddr   (s1_araddr),
        .s1_arprot   (s1_arprot),
        .s1_arvalid  (s1_arvalid),
        .s1_arready  (s1_arready),
        .s1_rdata    (s1_rdata),
        .s1_rresp    (s1_rresp),
        .s1_rvalid   (s1_rvalid),
        .s1_rready   (s1_rready),
        .m_araddr    (m_araddr),
        .m_arprot    (m_arprot),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2 ns after the rising edge.
    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic clear_inputs();
        s0_araddr = '0; s0_arprot = '0; s0_arvalid = 1'b0; s0_rready = 1'b0;
        s1_araddr = '0; s1_arprot = '0; s1_arvalid = 1'b0; s1_rready = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    // Single s0 read with an immediately responsive slave and rready high.
    task automatic s0_read(input string tag, input logic [3:0] addr,
                           input logic [31:0] data, input logic [1:0] resp);
        s0_araddr = addr; s0_arvalid = 1'b1; s0_rready = 1'b1;
        #1;
        chk({tag, "_arready"}, 32'(s0_arready), 32'd1);
        tick();
        s0_arvalid = 1'b0; m_arready = 1'b1;
        chk({tag, "_araddr"}, 32'(m_araddr), 32'(addr));
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = data; m_rresp = resp;
        tick();
        m_rvalid = 1'b0;
        chk({tag, "_rvalid"}, 32'(s0_rvalid), 32'd1);
        chk({tag, "_rdata"},  s0_rdata, data);
        chk({tag, "_rresp"},  32'(s0_rresp), 32'(resp));
        tick();
        chk({tag, "_idle_grant"}, 32'(grant), 32'd0);
    endtask

    initial begin
        logic [31:0] own_rdata;
        logic [3:0]  addr_seq [3];
        int          own_seq  [3];
        addr_seq = '{4'h4, 4'h8, 4'h4};
        own_seq  = '{0, 1, 0};

        // ---------------- reset values ----------------
        clear_inputs();
        aresetn = 1'b0;
        tick();
        chk("rst_grant",   32'(grant),       32'd0);
        chk("rst_arvalid", 32'(m_arvalid),   32'd0);
        chk("rst_rready",  32'(m_rready),    32'd0);
        chk("rst_araddr",  32'(m_araddr),    32'd0);
        chk("rst_to",      32'(timeout_err), 32'd0);
        chk("rst_s0rv",    32'(s0_rvalid),   32'd0);
        tick();
        aresetn = 1'b1;
        tick();

        // ---------------- tie, both held: order s0, s1, s0 ----------------
        s0_arvalid = 1'b1; s0_araddr = 4'h4;
        s1_arvalid = 1'b1; s1_araddr = 4'h8;
        s0_rready = 1'b1; s1_rready = 1'b1;
        m_arready = 1'b1; m_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rr_s0_arready", 32'(s0_arready), 32'(own_seq[i] == 0));
            chk("rr_s1_arready", 32'(s1_arready), 32'(own_seq[i] == 1));
            m_rdata = 32'h100 + 32'(i);
            tick();
            chk("rr_grant",   32'(grant),     (own_seq[i] == 0) ? 32'd1 : 32'd2);
            chk("rr_araddr",  32'(m_araddr),  32'(addr_seq[i]));
            chk("rr_arvalid", 32'(m_arvalid), 32'd1);
            tick();
            chk("rr_rready",  32'(m_rready),  32'd1);
            tick();
            own_rdata = (own_seq[i] == 1) ? s1_rdata : s0_rdata;
            chk("rr_rvalid", (own_seq[i] == 1) ? 32'(s1_rvalid) : 32'(s0_rvalid), 32'd1);
            chk("rr_rdata",  own_rdata, 32'h100 + 32'(i));
            tick();
        end
        clear_inputs();
        tick();

        // ---------------- single s0 read, DEADBEEF ----------------
        s0_arvalid = 1'b1; s0_araddr = 4'hC; s0_arprot = 3'b010; s0_rready = 1'b1;
        #1;
        chk("t1_s0_arready", 32'(s0_arready), 32'd1);
        chk("t1_s1_arready", 32'(s1_arready), 32'd0);
        tick();
        s0_arvalid = 1'b0;
        chk("t1_arvalid", 32'(m_arvalid), 32'd1);
        chk("t1_araddr",  32'(m_araddr),  32'hC);
        chk("t1_arprot",  32'(m_arprot),  32'd2);
        chk("t1_grant_a", 32'(grant),     32'd1);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        chk("t1_rready",    32'(m_rready),  32'd1);
        chk("t1_arvalid_d", 32'(m_arvalid), 32'd0);
        m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00;
        tick();
        m_rvalid = 1'b0;
        chk("t1_s0_rvalid", 32'(s0_rvalid), 32'd1);
        chk("t1_s0_rdata",  s0_rdata,       32'hDEADBEEF);
        chk("t1_s0_rresp",  32'(s0_rresp),  32'd0);
        chk("t1_s1_rvalid", 32'(s1_rvalid), 32'd0);
        chk("t1_s1_rdata",  s1_rdata,       32'd0);
        chk("t1_grant_r",   32'(grant),     32'd1);
        tick();
        chk("t1_grant_i",   32'(grant),     32'd0);
        chk("t1_rvalid_i",  32'(s0_rvalid), 32'd0);

        // ---------------- AR stall 40 cycles, then R timeout ----------------
        s0_arvalid = 1'b1; s0_araddr = 4'hA; s0_rready = 1'b0;
        tick();
        s0_arvalid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            chk("st_arvalid", 32'(m_arvalid),   32'd1);
            chk("st_araddr",  32'(m_araddr),    32'hA);
            chk("st_to",      32'(timeout_err), 32'd0);
            tick();
        end
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("to_rready_d", 32'(m_rready),  32'd1);
            chk("to_rvalid_d", 32'(s0_rvalid), 32'd0);
            tick();
        end
        tick();
        chk("to_rvalid",  32'(s0_rvalid),   32'd1);
        chk("to_rresp",   32'(s0_rresp),    32'd2);
        chk("to_rdata",   s0_rdata,         32'd0);
        chk("to_pulse",   32'(timeout_err), 32'd1);
        chk("to_drain",   32'(m_rready),    32'd1);
        tick();
        chk("to_pulse_1", 32'(timeout_err), 32'd0);
        chk("to_hold",    32'(s0_rvalid),   32'd1);
        m_rvalid = 1'b1; m_rdata = 32'h1234;
        tick();
        m_rvalid = 1'b0;
        chk("dr_rready",  32'(m_rready),  32'd0);
        chk("dr_rdata",   s0_rdata,       32'd0);
        chk("dr_rresp",   32'(s0_rresp),  32'd2);
        s0_rready = 1'b1;
        tick();
        chk("dr_grant",   32'(grant),     32'd0);
        s0_read("after_drain", 4'h3, 32'h5555AAAA, 2'b00);

        // ---------------- m_rvalid in the threshold cycle wins ----------------
        s0_arvalid = 1'b1; s0_araddr = 4'h5;
        tick();
        s0_arvalid = 1'b0; m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("th_still_data", 32'(s0_rvalid), 32'd0);
        m_rvalid = 1'b1; m_rdata = 32'hABCD0123; m_rresp = 2'b00;
        tick();
        m_rvalid = 1'b0;
        chk("th_rdata",  s0_rdata,         32'hABCD0123);
        chk("th_rresp",  32'(s0_rresp),    32'd0);
        chk("th_to",     32'(timeout_err), 32'd0);
        tick();
        chk("th_rready", 32'(m_rready),    32'd0);

        // ---------------- s1 holds rready low in RESP ----------------
        reset_dut();
        s1_arvalid = 1'b1; s1_araddr = 4'h6;
        #1;
        chk("hr_s1_arready", 32'(s1_arready), 32'd1);
        tick();
        s1_arvalid = 1'b0; m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b01;
        tick();
        m_rvalid = 1'b0;
        s0_arvalid = 1'b1; s0_araddr = 4'h9;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("hr_s1_rvalid",  32'(s1_rvalid),  32'd1);
            chk("hr_s1_rdata",   s1_rdata,        32'hCAFEF00D);
            chk("hr_s1_rresp",   32'(s1_rresp),   32'd1);
            chk("hr_s0_arready", 32'(s0_arready), 32'd0);
            tick();
        end
        s1_rready = 1'b1;
        tick();
        #1;
        chk("hr_grant_i",   32'(grant),      32'd0);
        chk("hr_s0_arrdy",  32'(s0_arready), 32'd1);
        tick();
        s0_arvalid = 1'b0;
        chk("hr_s0_grant",  32'(grant),      32'd1);
        chk("hr_s0_araddr", 32'(m_araddr),   32'h9);

        // ---------------- reset asserted in DATA ----------------
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        chk("ar_in_data", 32'(m_rready), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("ar_rready",  32'(m_rready),  32'd0);
        chk("ar_grant",   32'(grant),     32'd0);
        chk("ar_araddr",  32'(m_araddr),  32'd0);
        chk("ar_arvalid", 32'(m_arvalid), 32'd0);
        chk("ar_s0rv",    32'(s0_rvalid), 32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        s0_read("post_rst", 4'h2, 32'h77777777, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
